// File: rtl/laser_unit.sv
// Player laser: launches from the ship nose, climbs once per frame,
// ends on alien hit or top edge, then waits out a fire cooldown.
//
// Ports:
//   clk, reset    system clock, async active-high reset
//   x, y          current pixel column/row from the VGA timing
//   shoot         debounced shoot level
//   enable        play screen active; low clears all state
//   ship_x/ship_y ship left/top edge
//   alien_hit     one-cycle hit pulse from the alien unit
//   laser_x/y     laser top-left corner (registered)
//   laser_active  high while the laser is flying
//   shot_fired    one-cycle pulse on launch
//   laser_color   RGB332 overlay, 0 when not drawing
module laser_unit #(
  parameter int LASER_W         = 2,
  parameter int LASER_H         = 8,
  parameter int SPEED           = 4,
  parameter int SHIP_W          = 16,
  parameter int COOLDOWN_FRAMES = 30,
  parameter logic [7:0] LASER_COLOR = 8'b000_111_00,
  parameter int FRAME_LINE      = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       shoot,
  input  logic       enable,
  input  logic [9:0] ship_x,
  input  logic [9:0] ship_y,
  input  logic       alien_hit,
  output logic [9:0] laser_x,
  output logic [9:0] laser_y,
  output logic       laser_active,
  output logic       shot_fired,
  output logic [7:0] laser_color
);

  localparam logic [9:0] NOSE_OFS = 10'(SHIP_W / 2 - LASER_W / 2);
  localparam logic [9:0] LH       = 10'(LASER_H);
  localparam logic [9:0] SPD      = 10'(SPEED);
  localparam logic [7:0] CD       = 8'(COOLDOWN_FRAMES);
  localparam logic [9:0] FL       = 10'(FRAME_LINE);

  typedef enum logic [1:0] {
    IDLE,
    FLY,
    COOL
  } state_t;

  state_t     state, state_n;
  logic [9:0] lx_n, ly_n;
  logic [7:0] count, count_n;
  logic       pending, pending_n;
  logic       active_n, fired_n;
  logic       shoot_q, frame_q;
  logic       at_line, frame_tick, shoot_edge;

  // y sits on the frame line for many clocks; take only the first.
  assign at_line    = (y == FL);
  assign frame_tick = at_line & ~frame_q;
  assign shoot_edge = shoot & ~shoot_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      laser_x      <= '0;
      laser_y      <= '0;
      laser_active <= 1'b0;
      shot_fired   <= 1'b0;
      pending      <= 1'b0;
      count        <= '0;
      shoot_q      <= 1'b0;
      frame_q      <= 1'b0;
    end else if (!enable) begin
      state        <= IDLE;
      laser_x      <= '0;
      laser_y      <= '0;
      laser_active <= 1'b0;
      shot_fired   <= 1'b0;
      pending      <= 1'b0;
      count        <= '0;
      shoot_q      <= 1'b0;
      frame_q      <= 1'b0;
    end else begin
      state        <= state_n;
      laser_x      <= lx_n;
      laser_y      <= ly_n;
      laser_active <= active_n;
      shot_fired   <= fired_n;
      pending      <= pending_n;
      count        <= count_n;
      shoot_q      <= shoot;
      frame_q      <= at_line;
    end
  end

  always_comb begin
    state_n   = state;
    lx_n      = laser_x;
    ly_n      = laser_y;
    count_n   = count;
    pending_n = 1'b0;
    fired_n   = 1'b0;
    unique case (state)
      IDLE: begin
        pending_n = pending | shoot_edge;
        if (frame_tick && pending) begin
          state_n   = FLY;
          lx_n      = ship_x + NOSE_OFS;
          ly_n      = (ship_y < LH) ? '0 : ship_y - LH;
          pending_n = 1'b0;
          fired_n   = 1'b1;
        end
      end
      FLY: begin
        // A hit beats a same-cycle move.
        if (alien_hit) begin
          state_n = COOL;
          count_n = CD;
        end else if (frame_tick) begin
          if (laser_y < SPD) begin
            state_n = COOL;
            count_n = CD;
          end else begin
            ly_n = laser_y - SPD;
          end
        end
      end
      COOL: begin
        if (frame_tick) begin
          count_n = count - 8'd1;
          if (count == 8'd1) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    active_n = (state_n == FLY);
  end

  // 11-bit sums keep the right/bottom edge compare from wrapping.
  logic in_x, in_y;
  assign in_x = ({1'b0, x} >= {1'b0, laser_x}) &&
                ({1'b0, x} <  {1'b0, laser_x} + 11'(LASER_W));
  assign in_y = ({1'b0, y} >= {1'b0, laser_y}) &&
                ({1'b0, y} <  {1'b0, laser_y} + 11'(LASER_H));

  assign laser_color = (laser_active && in_x && in_y) ? LASER_COLOR : 8'h00;

endmodule

// File: tb/tb_laser_unit.sv
// Directed bench for laser_unit: launch, flight, hit, cooldown,
// shot discard, top-edge launch, reset and enable clears.
module tb_laser_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] x = '0;
  logic [9:0] y = '0;
  logic       shoot = 1'b0;
  logic       enable = 1'b0;
  logic [9:0] ship_x = 10'd300;
  logic [9:0] ship_y = 10'd440;
  logic       alien_hit = 1'b0;
  logic [9:0] laser_x, laser_y;
  logic       laser_active, shot_fired;
  logic [7:0] laser_color;

  int checks = 0;
  int errors = 0;
  int launches = 0;
  int fired_cnt = 0;
  logic [19:0] exp_q[$];

  laser_unit dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .shoot(shoot),
    .enable(enable), .ship_x(ship_x), .ship_y(ship_y),
    .alien_hit(alien_hit), .laser_x(laser_x), .laser_y(laser_y),
    .laser_active(laser_active), .shot_fired(shot_fired),
    .laser_color(laser_color)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame line held two clocks: only one tick may result.
  task automatic tick(input logic hit = 1'b0);
    y = 10'd480;
    alien_hit = hit;
    step();
    alien_hit = 1'b0;
    step();
    y = 10'd0;
    step();
  endtask

  task automatic press();
    shoot = 1'b1;
    step();
    shoot = 1'b0;
    step();
  endtask

  task automatic expect_launch(input logic [9:0] ex, input logic [9:0] ey);
    exp_q.push_back({ex, ey});
    launches++;
  endtask

  task automatic pix(input string tag, input logic [9:0] px,
                     input logic [9:0] py, input logic [7:0] exp);
    x = px;
    y = py;
    #1;
    check(tag, {24'd0, laser_color}, {24'd0, exp});
    y = 10'd0;
  endtask

  // Scoreboard: each launch pulse consumes one expected launch point.
  always @(negedge clk) begin
    if (shot_fired) begin
      fired_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_shot", 32'd1, 32'd0);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        check("launch_pos", {12'd0, laser_x, laser_y}, {12'd0, e});
        check("launch_active", {31'd0, laser_active}, 32'd1);
      end
    end
  end

  initial begin
    step();
    check("rst_active", {31'd0, laser_active}, 32'd0);
    check("rst_xy", {12'd0, laser_x, laser_y}, 32'd0);
    check("rst_fired", {31'd0, shot_fired}, 32'd0);
    check("rst_color", {24'd0, laser_color}, 32'd0);
    reset = 1'b0;
    enable = 1'b1;
    step();

    // Hit pulse in IDLE is ignored; first launch.
    alien_hit = 1'b1;
    step();
    alien_hit = 1'b0;
    press();
    check("pending_wait", {31'd0, laser_active}, 32'd0);
    expect_launch(10'd307, 10'd432);
    tick();
    check("fly_active", {31'd0, laser_active}, 32'd1);
    check("fly_xy", {12'd0, laser_x, laser_y}, {12'd0, 10'd307, 10'd432});
    pix("pix_hit", 10'd307, 10'd432, 8'h1C);
    pix("pix_right", 10'd309, 10'd432, 8'h00);
    pix("pix_below", 10'd307, 10'd440, 8'h00);
    pix("pix_corner", 10'd308, 10'd439, 8'h1C);
    pix("pix_left", 10'd306, 10'd435, 8'h00);

    // Climb to the top; a press mid-flight must be dropped.
    for (int k = 1; k <= 108; k++) begin
      if (k == 50) press();
      tick();
      check("climb_y", {22'd0, laser_y}, 432 - 4 * k);
      check("climb_act", {31'd0, laser_active}, 32'd1);
    end
    tick();
    check("top_exit", {31'd0, laser_active}, 32'd0);

    // Cooldown: press at tick 29 is dropped, IDLE after tick 30.
    for (int k = 1; k <= 29; k++) tick();
    press();
    tick();
    check("cool_noshot", {31'd0, laser_active}, 32'd0);
    press();
    expect_launch(10'd307, 10'd432);
    tick();
    check("relaunch", {31'd0, laser_active}, 32'd1);

    // Hit on the same cycle as a frame tick at y=200.
    for (int k = 1; k <= 58; k++) tick();
    check("at_200", {22'd0, laser_y}, 32'd200);
    y = 10'd480;
    alien_hit = 1'b1;
    step();
    alien_hit = 1'b0;
    check("hit_y", {22'd0, laser_y}, 32'd200);
    check("hit_active", {31'd0, laser_active}, 32'd0);
    step();
    y = 10'd0;
    step();
    for (int k = 1; k <= 15; k++) tick();
    press();
    for (int k = 16; k <= 30; k++) tick();
    tick();
    check("no_press_idle", {31'd0, laser_active}, 32'd0);

    // Launch near the top edge clamps to row 0.
    ship_y = 10'd4;
    press();
    expect_launch(10'd307, 10'd0);
    tick();
    check("clamp_y", {22'd0, laser_y}, 32'd0);
    check("clamp_act", {31'd0, laser_active}, 32'd1);
    tick();
    check("clamp_end", {31'd0, laser_active}, 32'd0);
    for (int k = 1; k <= 30; k++) tick();

    // Async reset mid-flight at y=100.
    ship_y = 10'd440;
    press();
    expect_launch(10'd307, 10'd432);
    tick();
    for (int k = 1; k <= 83; k++) tick();
    check("at_100", {22'd0, laser_y}, 32'd100);
    pix("pix_100", 10'd307, 10'd100, 8'h1C);
    x = 10'd307;
    y = 10'd100;
    reset = 1'b1;
    #1;
    check("rst_mid_act", {31'd0, laser_active}, 32'd0);
    check("rst_mid_color", {24'd0, laser_color}, 32'd0);
    check("rst_mid_y", {22'd0, laser_y}, 32'd0);
    y = 10'd0;
    step();
    reset = 1'b0;
    tick();
    check("rst_no_pend", {31'd0, laser_active}, 32'd0);
    press();
    expect_launch(10'd307, 10'd432);
    tick();
    check("rst_idle", {31'd0, laser_active}, 32'd1);

    // Enable drop mid-flight at y=100.
    for (int k = 1; k <= 83; k++) tick();
    x = 10'd307;
    y = 10'd100;
    enable = 1'b0;
    step();
    check("en_act", {31'd0, laser_active}, 32'd0);
    check("en_color", {24'd0, laser_color}, 32'd0);
    y = 10'd0;
    enable = 1'b1;
    tick();
    check("en_no_pend", {31'd0, laser_active}, 32'd0);
    press();
    expect_launch(10'd307, 10'd432);
    tick();
    check("en_idle", {31'd0, laser_active}, 32'd1);

    step();
    check("shots", fired_cnt, launches);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
